seven_seg_debug_display: RTL and testbench

- Board-level consumer of the processor's debug outputs (PCValue, WriteData, HiData, LoData), instantiated beside the pipeline top level on the FPGA.
- Selects one 32-bit source and snapshots it once per scan frame, so the value does not tear mid-frame.
- Time-multiplexes the snapshot as 8 hex digits onto a common-anode 8-digit seven-segment display.
- Supports freezing the displayed value for single-step debugging.

---
 rtl/seven_seg_debug_display_if.sv | 22 ++
 rtl/seven_seg_debug_display.sv | 95 +++++++++
 tb/tb_seven_seg_debug_display.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_debug_display_if.sv
// rtl/seven_seg_debug_display_if.sv - debug sources, controls and display drive for the 7-seg debug display
interface seven_seg_debug_display_if;
  logic [31:0] PCValue;
  logic [31:0] WriteData;
  logic [31:0] HiData;
  logic [31:0] LoData;
  logic [1:0]  Sel;
  logic        Freeze;
  logic [7:0]  Anode;
  logic [6:0]  Segments;
  logic        DP;

  modport master (
    output PCValue, WriteData, HiData, LoData, Sel, Freeze,
    input  Anode, Segments, DP
  );

  modport slave (
    input  PCValue, WriteData, HiData, LoData, Sel, Freeze,
    output Anode, Segments, DP
  );
endinterface

// File: rtl/seven_seg_debug_display.sv
// rtl/seven_seg_debug_display.sv - frame-snapshotted 8-digit hex scan of a selected processor debug word
module seven_seg_debug_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                        Clk,
  input  logic                        Rst,
  seven_seg_debug_display_if.slave    dbg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_refresh_cnt;
  logic [2:0]    r_digit_idx;
  logic [31:0]   r_snapshot;
  logic          r_freeze_q;
  logic [7:0]    r_anode;
  logic [6:0]    r_segments;
  logic          r_dp;

  logic          w_tick;
  logic [31:0]   w_src;
  logic [3:0]    w_nibble;
  logic [6:0]    w_pattern;

  assign w_tick   = (r_refresh_cnt == CNT_MAX);
  assign w_nibble = r_snapshot[{r_digit_idx, 2'b00} +: 4];

  always_comb begin
    w_src = dbg.PCValue;
    case (dbg.Sel)
      2'd0: w_src = dbg.PCValue;
      2'd1: w_src = dbg.WriteData;
      2'd2: w_src = dbg.HiData;
      2'd3: w_src = dbg.LoData;
      default: w_src = dbg.PCValue;
    endcase
  end

  // Patterns are {g,f,e,d,c,b,a}, active-low for a common-anode display
  always_comb begin
    w_pattern = 7'b1111111;
    case (w_nibble)
      4'h0: w_pattern = 7'b1000000;
      4'h1: w_pattern = 7'b1111001;
      4'h2: w_pattern = 7'b0100100;
      4'h3: w_pattern = 7'b0110000;
      4'h4: w_pattern = 7'b0011001;
      4'h5: w_pattern = 7'b0010010;
      4'h6: w_pattern = 7'b0000010;
      4'h7: w_pattern = 7'b1111000;
      4'h8: w_pattern = 7'b0000000;
      4'h9: w_pattern = 7'b0010000;
      4'hA: w_pattern = 7'b0001000;
      4'hB: w_pattern = 7'b0000011;
      4'hC: w_pattern = 7'b1000110;
      4'hD: w_pattern = 7'b0100001;
      4'hE: w_pattern = 7'b0000110;
      4'hF: w_pattern = 7'b0001110;
      default: w_pattern = 7'b1111111;
    endcase
  end

  // Snapshot only reloads as digit 7 finishes, so one frame never mixes two values
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 3'd0;
      r_snapshot    <= 32'h0;
      r_freeze_q    <= 1'b0;
      r_anode       <= 8'hFF;
      r_segments    <= 7'h7F;
      r_dp          <= 1'b1;
    end else begin
      r_freeze_q <= dbg.Freeze;
      if (w_tick) begin
        r_refresh_cnt <= '0;
        r_digit_idx   <= r_digit_idx + 3'd1;
        if (r_digit_idx == 3'd7 && !dbg.Freeze) begin
          r_snapshot <= w_src;
        end
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      r_anode    <= ~(8'b1 << r_digit_idx);
      r_segments <= w_pattern;
      r_dp       <= !(r_digit_idx == 3'd0 && r_freeze_q);
    end
  end

  assign dbg.Anode    = r_anode;
  assign dbg.Segments = r_segments;
  assign dbg.DP       = r_dp;

endmodule

// File: tb/tb_seven_seg_debug_display.sv
// tb/tb_seven_seg_debug_display.sv - randomized bench for seven_seg_debug_display against a cycle-count reference model
module tb_seven_seg_debug_display;

  localparam int DIV = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  seven_seg_debug_display_if dbg ();

  seven_seg_debug_display #(.REFRESH_DIV(DIV)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .dbg (dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] hex_tbl [16];
  int          k;
  logic [31:0] m_snap;
  logic        m_fq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s);
    case (s)
      2'd0: return dbg.PCValue;
      2'd1: return dbg.WriteData;
      2'd2: return dbg.HiData;
      default: return dbg.LoData;
    endcase
  endfunction

  function automatic int cur_digit(input int edge_no);
    return ((edge_no - 1) / DIV) % 8;
  endfunction

  task automatic model_reset();
    k = 0;
    m_snap = 32'h0;
    m_fq = 1'b0;
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, "_anode"}, {24'h0, dbg.Anode}, 32'hFF);
    check_eq({tag, "_seg"}, {25'h0, dbg.Segments}, 32'h7F);
    check_eq({tag, "_dp"}, {31'h0, dbg.DP}, 32'h1);
  endtask

  // One clock: outputs at edge k reflect the digit position and snapshot held before that edge
  task automatic step();
    int d;
    logic [3:0] nib;
    @(posedge Clk);
    k++;
    d = cur_digit(k);
    nib = 4'((m_snap >> (4 * d)) & 32'hF);
    #1;
    check_eq("anode", {24'h0, dbg.Anode}, {24'h0, ~(8'h01 << d)});
    check_eq("segments", {25'h0, dbg.Segments}, {25'h0, hex_tbl[nib]});
    check_eq("dp", {31'h0, dbg.DP}, {31'h0, !(d == 0 && m_fq)});
    if ((k % (8 * DIV)) == 0 && !dbg.Freeze) m_snap = pick(dbg.Sel);
    m_fq = dbg.Freeze;
  endtask

  task automatic randomize_inputs(input int sel_odds, input int frz_odds);
    dbg.PCValue   = $urandom;
    dbg.WriteData = $urandom;
    dbg.HiData    = $urandom;
    dbg.LoData    = $urandom;
    if ($urandom_range(sel_odds - 1, 0) == 0) dbg.Sel = 2'($urandom_range(3, 0));
    if ($urandom_range(frz_odds - 1, 0) == 0) dbg.Freeze = ~dbg.Freeze;
  endtask

  initial begin
    int guard;
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    dbg.PCValue = 32'h0040_00A8;
    dbg.WriteData = 32'h1234_5678;
    dbg.HiData = 32'hDEAD_BEEF;
    dbg.LoData = 32'hCAFE_F00D;
    dbg.Sel = 2'd0;
    dbg.Freeze = 1'b0;
    model_reset();

    repeat (3) begin
      @(posedge Clk);
      #1;
      check_blank("reset");
    end

    Rst = 1'b1;
    repeat (64) step();

    repeat (12) step();
    dbg.Sel = 2'd2;
    repeat (84) step();

    repeat (20) step();
    dbg.Freeze = 1'b1;
    repeat (20) step();
    dbg.LoData = 32'h0BAD_F00D;
    dbg.Sel = 2'd3;
    repeat (96) step();
    dbg.Freeze = 1'b0;
    repeat (64) step();

    for (int i = 0; i < 2000; i++) begin
      randomize_inputs(8, 40);
      step();
    end

    dbg.Freeze = 1'b0;
    guard = 0;
    while (!(cur_digit(k + 1) == 5 && ((k) % DIV) == 1) && guard < 100) begin
      randomize_inputs(8, 1000);
      step();
      guard++;
    end
    check_eq("midscan_reach", 32'(guard < 100), 32'h1);
    #2;
    Rst = 1'b0;
    #1;
    check_blank("async_rst");
    repeat (2) begin
      @(posedge Clk);
      #1;
      check_blank("rst_hold");
    end
    model_reset();
    Rst = 1'b1;
    repeat (40) begin
      randomize_inputs(8, 1000);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
